// File: rtl/aes_key_schedule_seq.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_seq
//
// Sequential AES key expansion for AES-128/192/256, one 32-bit schedule word
// per clock. The key words are loaded in one cycle on an accepted start. Each
// following cycle derives w[i] from w[i-1] and w[i-Nk] through a single shared
// SubWord datapath. All words live in an internal word store. Round keys are
// read back combinationally by round index.
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset (priority over all inputs)
//   start       request a new expansion, sampled only in IDLE
//   key_len     0=AES-128, 1=AES-192, 2=AES-256, 3=treated as AES-128
//   key_in      cipher key, left-aligned (w[0] = key_in[top 32 bits])
//   busy        expansion in progress
//   done        one-cycle pulse after the last word is written
//   keys_valid  level, round keys readable
//   nr          Nr of the stored schedule (10/12/14), 0 after reset
//   rk_rd_idx   round-key index 0..Nr
//   rk_rd_data  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}. Zero when no
//               valid schedule is stored or the index is out of range.
// ---------------------------------------------------------------------------
module aes_key_schedule_seq #(
    parameter int MAX_NK = 8,
    parameter int RIDX_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [MAX_NK*32-1:0]  key_in,
    output logic                  busy,
    output logic                  done,
    output logic                  keys_valid,
    output logic [3:0]            nr,
    input  logic [RIDX_W-1:0]     rk_rd_idx,
    output logic [127:0]          rk_rd_data
);

    localparam int NWORDS = 4 * (MAX_NK + 7);
    localparam int WIDX_W = $clog2(NWORDS);
    localparam int NK_W   = $clog2(MAX_NK + 1);
    localparam int J_W    = $clog2(MAX_NK);
    localparam int MAX_NR = MAX_NK + 6;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;

    state_t state_reg, state_next;

    logic [31:0]       store_reg [NWORDS];
    logic [WIDX_W-1:0] i_reg;          // index of the word being written
    logic [J_W-1:0]    j_reg;          // i mod Nk, kept as a wrapping counter
    logic [7:0]        rcon_reg;
    logic [NK_W-1:0]   nk_reg;
    logic [3:0]        nr_lat_reg;     // Nr of the run in progress
    logic [WIDX_W-1:0] last_idx_reg;   // Nw-1
    logic [3:0]        nr_reg;         // Nr of the stored, valid schedule
    logic              keys_valid_reg;

    // key_len decode, only used on an accepted start
    logic [NK_W-1:0]   nk_sel;
    logic [3:0]        nr_sel;

    always_comb begin
        nk_sel = NK_W'(4);
        nr_sel = 4'd10;
        case (key_len)
            2'd1: begin
                nk_sel = NK_W'(6);
                nr_sel = 4'd12;
            end
            2'd2: begin
                nk_sel = NK_W'(8);
                nr_sel = 4'd14;
            end
            default: ;
        endcase
    end

    // Key words, w[0] taken from the most significant end of key_in
    logic [31:0] key_words [MAX_NK];

    generate
        for (genvar gi = 0; gi < MAX_NK; gi++) begin : g_key_words
            assign key_words[gi] = key_in[MAX_NK*32-1-32*gi -: 32];
        end
    endgenerate

    // Word datapath
    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] new_word;
    logic        j_zero;
    logic        j_wrap;
    logic        nk8_mid;

    assign prev_word = store_reg[i_reg - WIDX_W'(1)];
    assign back_word = store_reg[i_reg - WIDX_W'(nk_reg)];
    assign j_zero    = (j_reg == '0);
    assign j_wrap    = (NK_W'(j_reg) == nk_reg - NK_W'(1));
    assign nk8_mid   = (nk_reg == NK_W'(8)) && (j_reg == J_W'(4));

    // One shared SubWord. RotWord is applied in front of it only on the
    // i%Nk==0 words.
    assign sub_in = j_zero ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            assign sub_out[8*gi +: 8] = SBOX[sub_in[8*gi +: 8]];
        end
    endgenerate

    always_comb begin
        new_word = back_word ^ prev_word;
        if (j_zero) begin
            new_word = back_word ^ sub_out ^ {rcon_reg, 24'h0};
        end else if (nk8_mid) begin
            new_word = back_word ^ sub_out;
        end
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_EXPAND;
            ST_EXPAND: if (i_reg == last_idx_reg) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_reg == ST_EXPAND);
        done = (state_reg == ST_DONE);
    end

    // Datapath registers and word store
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NWORDS; k++) begin
                store_reg[k] <= '0;
            end
            i_reg          <= '0;
            j_reg          <= '0;
            rcon_reg       <= '0;
            nk_reg         <= '0;
            nr_lat_reg     <= '0;
            last_idx_reg   <= '0;
            nr_reg         <= '0;
            keys_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < MAX_NK; k++) begin
                            if (k < int'(nk_sel)) begin
                                store_reg[k] <= key_words[k];
                            end
                        end
                        nk_reg         <= nk_sel;
                        nr_lat_reg     <= nr_sel;
                        last_idx_reg   <= WIDX_W'({nr_sel, 2'b00}) + WIDX_W'(3);
                        i_reg          <= WIDX_W'(nk_sel);
                        j_reg          <= '0;
                        rcon_reg       <= 8'h01;
                        keys_valid_reg <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    store_reg[i_reg] <= new_word;
                    i_reg            <= i_reg + WIDX_W'(1);
                    j_reg            <= j_wrap ? '0 : j_reg + J_W'(1);
                    if (j_zero) begin
                        rcon_reg <= xtime(rcon_reg);
                    end
                    if (i_reg == last_idx_reg) begin
                        keys_valid_reg <= 1'b1;
                        nr_reg         <= nr_lat_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign keys_valid = keys_valid_reg;
    assign nr         = nr_reg;

    // Read port. The index is clamped so the four word addresses stay inside
    // the store even when the request itself is rejected.
    logic              rd_ok;
    logic [RIDX_W-1:0] rk_idx_c;
    logic [WIDX_W-1:0] rk_base;
    logic [31:0]       rk_word [4];

    assign rd_ok    = keys_valid_reg && (int'(rk_rd_idx) <= int'(nr_reg));
    assign rk_idx_c = (int'(rk_rd_idx) > MAX_NR) ? '0 : rk_rd_idx;
    assign rk_base  = WIDX_W'({rk_idx_c, 2'b00});

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rk_read
            assign rk_word[gi] = store_reg[rk_base + WIDX_W'(gi)];
        end
    endgenerate

    assign rk_rd_data = rd_ok ? {rk_word[0], rk_word[1], rk_word[2], rk_word[3]} : 128'h0;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
module tb_aes_key_schedule_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   nr;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;

    aes_key_schedule_seq #(.MAX_NK(8), .RIDX_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_len    (key_len),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .nr         (nr),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data)
    );

    always #5 clk = ~clk;

    // Unused low key bits are filled with junk that must be ignored.
    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_cafef00d_01234567_89abcdef};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hfeedface_0badf00d};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Pulse start and wait for done. lat counts edges after the load edge,
    // bcnt counts sampled cycles with busy high. An optional second start is
    // pulsed during the run with another key and key_len=2.
    task automatic run(input logic [1:0] kl, input logic [255:0] key,
                       input int glitch_at, input logic [255:0] gkey,
                       output int lat, output int bcnt, output logic kv_load);
        @(negedge clk);
        key_len = kl;
        key_in  = key;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        kv_load = keys_valid;
        lat     = 0;
        bcnt    = busy ? 1 : 0;
        while (!done && lat < 200) begin
            if (lat == glitch_at) begin
                start   = 1'b1;
                key_len = 2'd2;
                key_in  = gkey;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic read_rk(input logic [3:0] idx);
        rk_rd_idx = idx;
        #1;
    endtask

    typedef struct {
        logic [1:0]   kl;
        logic [255:0] key;
        logic [3:0]   exp_nr;
        int           exp_lat;
        logic [3:0]   idx;
        logic [127:0] exp_rk;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   bcnt;
        logic kvl;

        vecs[0]  = '{2'd0, K128, 4'd10, 40, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1]  = '{2'd0, K128, 4'd10, 40, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2]  = '{2'd0, K128, 4'd10, 40, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3]  = '{2'd0, K128, 4'd10, 40, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[4]  = '{2'd0, K128, 4'd10, 40, 4'd11, 128'h0};
        vecs[5]  = '{2'd3, K128, 4'd10, 40, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[6]  = '{2'd1, K192, 4'd12, 46, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
        vecs[7]  = '{2'd1, K192, 4'd12, 46, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
        vecs[8]  = '{2'd1, K192, 4'd12, 46, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
        vecs[9]  = '{2'd1, K192, 4'd12, 46, 4'd13, 128'h0};
        vecs[10] = '{2'd2, K256, 4'd14, 52, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
        vecs[11] = '{2'd2, K256, 4'd14, 52, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde};
        vecs[12] = '{2'd2, K256, 4'd14, 52, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
        vecs[13] = '{2'd2, K256, 4'd14, 52, 4'd15, 128'h0};

        rst       = 1'b1;
        start     = 1'b0;
        key_len   = 2'd0;
        key_in    = '0;
        rk_rd_idx = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy",       128'(busy),       128'h0);
        check("reset done",       128'(done),       128'h0);
        check("reset keys_valid", 128'(keys_valid), 128'h0);
        check("reset nr",         128'(nr),         128'h0);
        check("reset rk_rd_data", rk_rd_data,       128'h0);
        rst = 1'b0;

        // Table-driven runs; consecutive rows also give back-to-back runs
        for (int v = 0; v < 14; v++) begin
            run(vecs[v].kl, vecs[v].key, -1, '0, lat, bcnt, kvl);
            check($sformatf("v%0d latency", v),       128'(lat),  128'(vecs[v].exp_lat));
            check($sformatf("v%0d busy cycles", v),   128'(bcnt), 128'(vecs[v].exp_lat));
            check($sformatf("v%0d kv in load", v),    128'(kvl),  128'h0);
            check($sformatf("v%0d nr", v),            128'(nr),   128'(vecs[v].exp_nr));
            read_rk(vecs[v].idx);
            check($sformatf("v%0d rk[%0d]", v, vecs[v].idx), rk_rd_data, vecs[v].exp_rk);
            @(negedge clk);
            check($sformatf("v%0d done pulse ends", v), 128'(done),       128'h0);
            check($sformatf("v%0d kv holds", v),        128'(keys_valid), 128'h1);
        end

        // Second start mid-EXPAND (with key_len changed to 2) is ignored
        run(2'd0, K128, 10, K256, lat, bcnt, kvl);
        check("glitch latency",     128'(lat),  128'd40);
        check("glitch busy cycles", 128'(bcnt), 128'd40);
        check("glitch nr",          128'(nr),   128'd10);
        read_rk(4'd10);
        check("glitch rk[10]", rk_rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Start during the DONE cycle is ignored
        start   = 1'b1;
        key_len = 2'd2;
        key_in  = K256;
        @(negedge clk);
        start = 1'b0;
        check("start in DONE busy", 128'(busy),       128'h0);
        check("start in DONE kv",   128'(keys_valid), 128'h1);
        read_rk(4'd1);
        check("start in DONE rk[1]", rk_rd_data, 128'ha0fafe1788542cb123a339392a6c7605);

        // Reset 20 cycles into an AES-256 run
        key_len = 2'd2;
        key_in  = K256;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre-reset busy", 128'(busy), 128'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        read_rk(4'd0);
        check("mid reset busy",       128'(busy),       128'h0);
        check("mid reset keys_valid", 128'(keys_valid), 128'h0);
        check("mid reset nr",         128'(nr),         128'h0);
        check("mid reset rk_rd_data", rk_rd_data,       128'h0);
        @(negedge clk);
        check("mid reset stays idle", 128'(busy), 128'h0);

        run(2'd0, K128, -1, '0, lat, bcnt, kvl);
        check("after reset latency", 128'(lat), 128'd40);
        read_rk(4'd1);
        check("after reset rk[1]", rk_rd_data, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(4'd10);
        check("after reset rk[10]", rk_rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
